ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Parametrised successor to the combinational MIPS main decoder.
- Decodes the instruction in ID and carries the resulting control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Adds a load-use interlock, a branch/jump squash, and a multi-cycle EX hold for mult/div.
- Sits between the IF/ID register and the datapath stage registers; all datapath muxes read control from this block.

Parameters:
- REG_ADDR_W, 5: register-address width.
- ALUOP_W, 4: ALU operation code width.
- MULDIV_LAT, 4: total cycles a mult/div spends in EX. 0 or 1 means no hold.
- HAZARD_EN, 1: 1 enables the load-use interlock; 0 disables it and stall comes from mult/div only.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  6  ID opcode field.
- id_funct  in  6  ID funct field.
- id_rs  in  REG_ADDR_W  ID rs field.
- id_rt  in  REG_ADDR_W  ID rt field.
- id_rd  in  REG_ADDR_W  ID rd field.
- flush_id  in  1  squash the instruction in ID (taken branch/jump).
- id_ext_op, id_lu_op, id_branch  out  1 each  combinational ID controls.
- id_pc_src  out  2  combinational: 0 seq, 1 j/jal, 2 jr/jalr.
- stall  out  1  hold PC and IF/ID this cycle.
- muldiv_busy  out  1  mult/div hold in progress.
- ex_valid  out  1  EX stage valid.
- ex_alu_op  out  ALUOP_W  EX ALU operation.
- ex_alu_src1  out  1  EX ALU operand-1 select.
- ex_alu_src2  out  1  EX ALU operand-2 select.
- ex_dest  out  REG_ADDR_W  EX destination register.
- ex_mem_read  out  1  EX holds a load.
- mem_valid  out  1  MEM stage valid.
- mem_read  out  1  MEM read strobe.
- mem_write  out  1  MEM write strobe.
- mem_dest  out  REG_ADDR_W  MEM destination register.
- wb_valid  out  1  WB stage valid.
- wb_reg_write  out  1  WB GPR write enable.
- wb_hilo_write  out  1  WB HI/LO write enable.
- wb_mem_to_reg  out  2  WB writeback select.
- wb_dest  out  REG_ADDR_W  WB destination register.

Behaviour:
- Reset (reset_n low at an edge):
  - All valid bits, all registered controls and all dests go to 0.
  - FSM goes to IDLE; kill flag clears.
  - stall = 0 and muldiv_busy = 0 in the cycle after release.
- Decode is combinational from id_opcode/id_funct:
  - ext_op = op != 0x0c; lu_op = op == 0x0f.
  - alu_op[2:0]: R-type 010, beq 001, andi 100, slti/sltiu 101, else 000. alu_op[3] = op[0].
  - alu_src1 = R-type sll/srl/sra; alu_src2 = not (R-type or beq).
  - Destination: jal → 31; R-type → rd; else rt.
  - mem_read = lw; mem_write = sw.
  - mem_to_reg: lw 1; jal/jalr 2; else 0.
  - reg_write is 0 for sw, beq, j, jr, mult(u) (0x18/0x19) and div(u) (0x1a/0x1b).
  - hilo_write = 1 for mult(u)/div(u). mfhi/mflo write rd.
- Invalid bundle: when a stage is invalid, every control in it reads 0.
- Advance: on each edge without ex_hold, MEM←EX and WB←MEM.
  - EX←decode with valid = id_valid & ~flush_id & ~kill & ~load_use.
  - Latency: ID→EX 1 edge, →MEM 2, →WB 3.
- Load-use (HAZARD_EN=1):
  - load_use = ex_valid & ex_mem_read & ex_dest != 0 & (ex_dest == id_rs | (ex_dest == id_rt & ID uses rt)).
  - ID uses rt for R-type, beq, sw.
  - Effect: EX loads a bubble, stall = 1 for exactly one cycle.
- Mult/div FSM, states IDLE and BUSY, counter width clog2(MULDIV_LAT):
  - A mult/div loaded into EX with MULDIV_LAT > 1: next state BUSY, cnt = MULDIV_LAT-1.
  - In BUSY: ex_hold = stall = muldiv_busy = 1; EX keeps its contents; MEM loads a bubble; WB still advances; cnt decrements.
  - Transition: cnt == 1 → IDLE at that edge. Total EX residence is MULDIV_LAT cycles.
- flush_id during ex_hold: sets a sticky kill flag. The next ID→EX load is a bubble, then kill clears.
- flush_id and load_use in the same cycle: bubble, one-cycle stall (ID is squashed either way).
- reset_n low mid-BUSY aborts: pipeline cleared, no mult/div retires.

Decomposition:
- ctrl_pkg holds:
  - opcode/funct localparams (0x00, 0x02–0x04, 0x0a–0x0c, 0x0f, 0x23, 0x2b; funct 0x00/02/03/08/09/10/12/18–1b).
  - MEM_TO_REG and PC_SRC encodings.
  - A packed ctrl_bundle_t struct.
- One sub-module, ctrl_decode: the purely combinational opcode/funct → bundle decoder. ctrl_pipe owns the stage registers, interlock and FSM.

Test Plan:
- Reset: reset_n low 2 cycles with id_valid=1 add → all outputs 0. After release, ex_valid=1 at the first edge and wb_valid=1 at the third, with wb_reg_write=1 and wb_dest=rd.
- Load-use: lw $8 then add $9,$8,$10 → stall=1 for one cycle, EX bubble, add in EX one cycle later. lw $0 then a consumer of $0 → no stall. HAZARD_EN=0 → no stall.
- Mult/div, MULDIV_LAT=4:
  - mult → stall and muldiv_busy high 3 cycles, mem_valid=0 for 3 cycles, mult reaches MEM on the 4th edge after entering EX.
  - At WB: wb_hilo_write=1, wb_reg_write=0.
  - MULDIV_LAT=1 → no stall.
- Flush: beq with flush_id=1 → next EX bubble. flush_id pulsed during the mult hold → first instruction loaded after the hold is a bubble.
- Decode spot checks:
  - jal → wb_dest=31, wb_mem_to_reg=2, reg_write=1.
  - sw → mem_write=1, reg_write=0.
  - andi → ext_op=0, alu_op=4'b0100.
  - jr → id_pc_src=2, reg_write=0.
- Reset mid-BUSY: reset_n low at the 2nd hold cycle → next cycle stall=0, all valid=0, FSM IDLE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings and control-bundle types for the MIPS control pipeline.
// Opcode/funct values, writeback/PC-select encodings and per-stage control structs.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    M2R_ALU  = 2'd0,
    M2R_MEM  = 2'd1,
    M2R_LINK = 2'd2
  } mem_to_reg_e;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'd0,
    PC_JUMP = 2'd1,
    PC_REG  = 2'd2
  } pc_src_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Full decode result for the instruction sitting in ID.
  typedef struct packed {
    logic        ext_op;
    logic        lu_op;
    logic        branch;
    pc_src_e     pc_src;
    logic [3:0]  alu_op;
    logic        alu_src1;
    logic        alu_src2;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        hilo_write;
    mem_to_reg_e mem_to_reg;
    logic        uses_rt;
  } ctrl_bundle_t;

  typedef struct packed {
    logic        alu_src1;
    logic        alu_src2;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        hilo_write;
    mem_to_reg_e mem_to_reg;
  } ex_ctrl_t;

  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        hilo_write;
    mem_to_reg_e mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic        reg_write;
    logic        hilo_write;
    mem_to_reg_e mem_to_reg;
  } wb_ctrl_t;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

  // mfhi/mflo are listed explicitly: they move HI/LO into rd like any ALU result.
  function automatic logic funct_writes_gpr(input logic [5:0] funct);
    logic w;
    unique case (funct)
      FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: w = 1'b0;
      FN_MFHI, FN_MFLO:                          w = 1'b1;
      default:                                   w = 1'b1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational main decoder: opcode/funct (plus rt/rd) to control bundle
// and destination register.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  output ctrl_bundle_t          ctrl,
  output logic [REG_ADDR_W-1:0] dest
);

  logic is_r;
  logic is_jr;
  logic is_jalr;
  logic is_md;

  assign is_r    = (opcode == OP_RTYPE);
  assign is_jr   = is_r && (funct == FN_JR);
  assign is_jalr = is_r && (funct == FN_JALR);
  assign is_md   = is_r && is_muldiv(funct);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ctrl = '0;
    dest = rt;

    ctrl.ext_op = (opcode != OP_ANDI);
    ctrl.lu_op  = (opcode == OP_LUI);
    ctrl.branch = (opcode == OP_BEQ);

    if (opcode == OP_J || opcode == OP_JAL) ctrl.pc_src = PC_JUMP;
    else if (is_jr || is_jalr)              ctrl.pc_src = PC_REG;
    else                                    ctrl.pc_src = PC_SEQ;

    unique case (opcode)
      OP_RTYPE:          ctrl.alu_op[2:0] = 3'b010;
      OP_BEQ:            ctrl.alu_op[2:0] = 3'b001;
      OP_ANDI:           ctrl.alu_op[2:0] = 3'b100;
      OP_SLTI, OP_SLTIU: ctrl.alu_op[2:0] = 3'b101;
      default:           ctrl.alu_op[2:0] = 3'b000;
    endcase
    ctrl.alu_op[3] = opcode[0];

    ctrl.alu_src1  = is_r && (funct inside {FN_SLL, FN_SRL, FN_SRA});
    ctrl.alu_src2  = !(is_r || opcode == OP_BEQ);
    ctrl.mem_read  = (opcode == OP_LW);
    ctrl.mem_write = (opcode == OP_SW);

    if (opcode == OP_LW)                    ctrl.mem_to_reg = M2R_MEM;
    else if (opcode == OP_JAL || is_jalr)   ctrl.mem_to_reg = M2R_LINK;
    else                                    ctrl.mem_to_reg = M2R_ALU;

    unique case (opcode)
      OP_SW, OP_BEQ, OP_J: ctrl.reg_write = 1'b0;
      OP_RTYPE:            ctrl.reg_write = funct_writes_gpr(funct);
      default:             ctrl.reg_write = 1'b1;
    endcase

    ctrl.hilo_write = is_md;
    ctrl.uses_rt    = is_r || opcode == OP_BEQ || opcode == OP_SW;

    if (opcode == OP_JAL) dest = '1;
    else if (is_r)        dest = rd;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: decodes ID and carries the control bundle through ID/EX,
// EX/MEM and MEM/WB with load-use interlock, branch squash and mult/div EX hold.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 4,
  parameter int MULDIV_LAT = 4,
  parameter int HAZARD_EN  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [5:0]            id_opcode,
  input  logic [5:0]            id_funct,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  flush_id,
  output logic                  id_ext_op,
  output logic                  id_lu_op,
  output logic                  id_branch,
  output logic [1:0]            id_pc_src,
  output logic                  stall,
  output logic                  muldiv_busy,
  output logic                  ex_valid,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic                  ex_alu_src1,
  output logic                  ex_alu_src2,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  ex_mem_read,
  output logic                  mem_valid,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [REG_ADDR_W-1:0] mem_dest,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic                  wb_hilo_write,
  output logic [1:0]            wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_dest
);

  localparam int CNT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

  ctrl_bundle_t          dec;
  logic [REG_ADDR_W-1:0] dec_dest;

  ctrl_decode #(.REG_ADDR_W(REG_ADDR_W)) u_decode (
    .opcode (id_opcode),
    .funct  (id_funct),
    .rt     (id_rt),
    .rd     (id_rd),
    .ctrl   (dec),
    .dest   (dec_dest)
  );

  md_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  kill_q;

  logic                  ex_valid_q, mem_valid_q, wb_valid_q;
  ex_ctrl_t              ex_ctrl_q, ex_ctrl_d;
  mem_ctrl_t             mem_ctrl_q, mem_ctrl_d;
  wb_ctrl_t              wb_ctrl_q, wb_ctrl_d;
  logic [ALUOP_W-1:0]    ex_alu_op_q;
  logic [REG_ADDR_W-1:0] ex_dest_q, mem_dest_q, wb_dest_q;

  logic ex_hold;
  logic load_use;
  logic load_valid;

  assign ex_hold = (state_q == MD_BUSY);

  // A load in EX whose result ID needs: $0 never creates a dependency.
  assign load_use = (HAZARD_EN != 0) && ex_valid_q && ex_ctrl_q.mem_read &&
                    (ex_dest_q != '0) &&
                    ((ex_dest_q == id_rs) || ((ex_dest_q == id_rt) && dec.uses_rt));

  assign load_valid = id_valid && !flush_id && !kill_q && !load_use;

  assign ex_ctrl_d = '{
    alu_src1:   dec.alu_src1,
    alu_src2:   dec.alu_src2,
    mem_read:   dec.mem_read,
    mem_write:  dec.mem_write,
    reg_write:  dec.reg_write,
    hilo_write: dec.hilo_write,
    mem_to_reg: dec.mem_to_reg
  };

  assign mem_ctrl_d = '{
    mem_read:   ex_ctrl_q.mem_read,
    mem_write:  ex_ctrl_q.mem_write,
    reg_write:  ex_ctrl_q.reg_write,
    hilo_write: ex_ctrl_q.hilo_write,
    mem_to_reg: ex_ctrl_q.mem_to_reg
  };

  assign wb_ctrl_d = '{
    reg_write:  mem_ctrl_q.reg_write,
    hilo_write: mem_ctrl_q.hilo_write,
    mem_to_reg: mem_ctrl_q.mem_to_reg
  };

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (MULDIV_LAT > 1 && load_valid && dec.hilo_write) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_W'(MULDIV_LAT - 1);
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking everywhere so each stage samples its upstream's pre-edge value.
    if (!reset_n) begin
      state_q     <= MD_IDLE;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_alu_op_q <= '0;
      ex_dest_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_dest_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_dest_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (ex_hold) begin
        // A squash arriving while EX is frozen is remembered for the next load.
        kill_q      <= kill_q | flush_id;
        mem_valid_q <= 1'b0;
        mem_ctrl_q  <= '0;
        mem_dest_q  <= '0;
      end else begin
        kill_q      <= 1'b0;
        ex_valid_q  <= load_valid;
        ex_ctrl_q   <= load_valid ? ex_ctrl_d : '0;
        ex_alu_op_q <= load_valid ? ALUOP_W'(dec.alu_op) : '0;
        ex_dest_q   <= load_valid ? dec_dest : '0;
        mem_valid_q <= ex_valid_q;
        mem_ctrl_q  <= mem_ctrl_d;
        mem_dest_q  <= ex_dest_q;
      end

      wb_valid_q <= mem_valid_q;
      wb_ctrl_q  <= wb_ctrl_d;
      wb_dest_q  <= mem_dest_q;
    end
  end

  assign id_ext_op     = dec.ext_op;
  assign id_lu_op      = dec.lu_op;
  assign id_branch     = dec.branch;
  assign id_pc_src     = dec.pc_src;
  assign stall         = ex_hold || load_use;
  assign muldiv_busy   = ex_hold;

  assign ex_valid      = ex_valid_q;
  assign ex_alu_op     = ex_alu_op_q;
  assign ex_alu_src1   = ex_ctrl_q.alu_src1;
  assign ex_alu_src2   = ex_ctrl_q.alu_src2;
  assign ex_dest       = ex_dest_q;
  assign ex_mem_read   = ex_ctrl_q.mem_read;

  assign mem_valid     = mem_valid_q;
  assign mem_read      = mem_ctrl_q.mem_read;
  assign mem_write     = mem_ctrl_q.mem_write;
  assign mem_dest      = mem_dest_q;

  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_ctrl_q.reg_write;
  assign wb_hilo_write = wb_ctrl_q.hilo_write;
  assign wb_mem_to_reg = wb_ctrl_q.mem_to_reg;
  assign wb_dest       = wb_dest_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed instruction vectors push expected WB
// bundles; a negedge monitor retires them. Instance 1 has no interlock, 2 has MULDIV_LAT=1.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [5:0] id_funct = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       flush_id = 1'b0;

  logic       id_ext_op_v [3], id_lu_op_v [3], id_branch_v [3];
  logic [1:0] id_pc_src_v [3];
  logic       stall_v [3], muldiv_busy_v [3];
  logic       ex_valid_v [3], ex_alu_src1_v [3], ex_alu_src2_v [3], ex_mem_read_v [3];
  logic [3:0] ex_alu_op_v [3];
  logic [4:0] ex_dest_v [3], mem_dest_v [3], wb_dest_v [3];
  logic       mem_valid_v [3], mem_read_v [3], mem_write_v [3];
  logic       wb_valid_v [3], wb_reg_write_v [3], wb_hilo_write_v [3];
  logic [1:0] wb_mem_to_reg_v [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ctrl_pipe #(
      .REG_ADDR_W (5),
      .ALUOP_W    (4),
      .MULDIV_LAT ((g == 2) ? 1 : 4),
      .HAZARD_EN  ((g == 1) ? 0 : 1)
    ) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .id_valid      (id_valid),
      .id_opcode     (id_opcode),
      .id_funct      (id_funct),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_rd         (id_rd),
      .flush_id      (flush_id),
      .id_ext_op     (id_ext_op_v[g]),
      .id_lu_op      (id_lu_op_v[g]),
      .id_branch     (id_branch_v[g]),
      .id_pc_src     (id_pc_src_v[g]),
      .stall         (stall_v[g]),
      .muldiv_busy   (muldiv_busy_v[g]),
      .ex_valid      (ex_valid_v[g]),
      .ex_alu_op     (ex_alu_op_v[g]),
      .ex_alu_src1   (ex_alu_src1_v[g]),
      .ex_alu_src2   (ex_alu_src2_v[g]),
      .ex_dest       (ex_dest_v[g]),
      .ex_mem_read   (ex_mem_read_v[g]),
      .mem_valid     (mem_valid_v[g]),
      .mem_read      (mem_read_v[g]),
      .mem_write     (mem_write_v[g]),
      .mem_dest      (mem_dest_v[g]),
      .wb_valid      (wb_valid_v[g]),
      .wb_reg_write  (wb_reg_write_v[g]),
      .wb_hilo_write (wb_hilo_write_v[g]),
      .wb_mem_to_reg (wb_mem_to_reg_v[g]),
      .wb_dest       (wb_dest_v[g])
    );
  end

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_fail = 0;
  logic [8:0] sb [$];
  logic [8:0] sb_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic fl);
    id_valid  = 1'b1;
    id_opcode = op;
    id_funct  = fn;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    flush_id  = fl;
  endtask

  task automatic idle;
    id_valid = 1'b0;
    flush_id = 1'b0;
  endtask

  task automatic push_wb(input logic rw, input logic hilo, input logic [1:0] m2r,
                         input logic [4:0] dest);
    sb.push_back({rw, hilo, m2r, dest});
  endtask

  // Monitor: retire one expected bundle per valid WB; an idle WB must read all-zero.
  always @(negedge clk) begin
    if (wb_valid_v[0]) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL wb_unexpected: got dest 0x%0h expected no retirement at %0t",
                 wb_dest_v[0], $time);
      end else begin
        sb_exp = sb.pop_front();
        check("wb_retire", 32'({wb_reg_write_v[0], wb_hilo_write_v[0],
                                wb_mem_to_reg_v[0], wb_dest_v[0]}), 32'(sb_exp));
      end
    end else begin
      check("wb_idle_zero", 32'({wb_reg_write_v[0], wb_hilo_write_v[0],
                                 wb_mem_to_reg_v[0], wb_dest_v[0]}), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two edges with an add waiting in ID.
    issue(OP_RTYPE, 6'h20, 5'd1, 5'd2, 5'd5, 1'b0);
    tick;
    tick;
    mid;
    check("rst_all_zero", 32'(|{ex_valid_v[0], ex_alu_op_v[0], ex_alu_src1_v[0],
          ex_alu_src2_v[0], ex_dest_v[0], ex_mem_read_v[0], mem_valid_v[0], mem_read_v[0],
          mem_write_v[0], mem_dest_v[0], wb_valid_v[0], wb_reg_write_v[0],
          wb_hilo_write_v[0], wb_mem_to_reg_v[0], wb_dest_v[0], stall_v[0],
          muldiv_busy_v[0]}), 32'd0);
    reset_n = 1'b1;
    push_wb(1'b1, 1'b0, 2'd0, 5'd5);
    tick;
    idle;
    mid;
    check("rel_ex_valid", 32'(ex_valid_v[0]), 32'd1);
    check("rel_stall", 32'({stall_v[0], muldiv_busy_v[0]}), 32'd0);
    check("add_alu_op", 32'(ex_alu_op_v[0]), 32'h2);
    check("add_alu_src2", 32'(ex_alu_src2_v[0]), 32'd0);
    tick;
    mid;
    check("rel_mem_valid", 32'(mem_valid_v[0]), 32'd1);
    tick;
    mid;
    check("rel_wb_valid", 32'(wb_valid_v[0]), 32'd1);
    check("rel_wb_rw_dest", 32'({wb_reg_write_v[0], wb_dest_v[0]}), 32'h25);

    // Load-use on rs: lw $8 then add $9,$8,$10.
    tick;
    issue(OP_LW, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
    push_wb(1'b1, 1'b0, 2'd1, 5'd8);
    mid;
    check("lw_no_stall", 32'(stall_v[0]), 32'd0);
    tick;
    issue(OP_RTYPE, 6'h20, 5'd8, 5'd10, 5'd9, 1'b0);
    mid;
    check("lu_stall", 32'(stall_v[0]), 32'd1);
    check("lu_nohazard_stall", 32'(stall_v[1]), 32'd0);
    check("lu_ex_mem_read", 32'({ex_mem_read_v[0], ex_dest_v[0]}), 32'h28);
    tick;
    mid;
    check("lu_bubble", 32'(ex_valid_v[0]), 32'd0);
    check("lu_stall_once", 32'(stall_v[0]), 32'd0);
    check("lu_mem_read", 32'(mem_read_v[0]), 32'd1);
    tick;
    push_wb(1'b1, 1'b0, 2'd0, 5'd9);
    idle;
    mid;
    check("lu_add_in_ex", 32'({ex_valid_v[0], ex_dest_v[0]}), 32'h29);

    // lw $0 followed by a $0 consumer never stalls.
    tick;
    issue(OP_LW, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0);
    push_wb(1'b1, 1'b0, 2'd1, 5'd0);
    tick;
    issue(OP_RTYPE, 6'h20, 5'd0, 5'd0, 5'd11, 1'b0);
    push_wb(1'b1, 1'b0, 2'd0, 5'd11);
    mid;
    check("lw0_no_stall", 32'(stall_v[0]), 32'd0);
    tick;
    idle;
    mid;
    check("lw0_consumer_ex", 32'(ex_dest_v[0]), 32'd11);

    // andi only writes rt, so a preceding lw of rt is not a hazard.
    tick;
    issue(OP_LW, 6'h00, 5'd1, 5'd12, 5'd0, 1'b0);
    push_wb(1'b1, 1'b0, 2'd1, 5'd12);
    tick;
    issue(OP_ANDI, 6'h00, 5'd2, 5'd12, 5'd0, 1'b0);
    push_wb(1'b1, 1'b0, 2'd0, 5'd12);
    mid;
    check("andi_no_stall", 32'(stall_v[0]), 32'd0);
    check("andi_ext_lu", 32'({id_ext_op_v[0], id_lu_op_v[0]}), 32'd0);
    tick;
    idle;
    mid;
    check("andi_alu_op", 32'(ex_alu_op_v[0]), 32'h4);
    check("andi_alu_src2", 32'(ex_alu_src2_v[0]), 32'd1);

    // sw: memory write, no register write.
    tick;
    issue(OP_SW, 6'h00, 5'd1, 5'd7, 5'd0, 1'b0);
    push_wb(1'b0, 1'b0, 2'd0, 5'd7);
    mid;
    check("sw_ext_op", 32'(id_ext_op_v[0]), 32'd1);
    tick;
    idle;
    tick;
    mid;
    check("sw_mem_strobes", 32'({mem_valid_v[0], mem_read_v[0], mem_write_v[0]}), 32'h5);

    // jal / jr.
    tick;
    issue(OP_JAL, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    push_wb(1'b1, 1'b0, 2'd2, 5'd31);
    mid;
    check("jal_pc_src", 32'(id_pc_src_v[0]), 32'd1);
    tick;
    idle;
    mid;
    check("jal_ex_dest", 32'(ex_dest_v[0]), 32'd31);
    tick;
    issue(OP_RTYPE, FN_JR, 5'd31, 5'd0, 5'd0, 1'b0);
    push_wb(1'b0, 1'b0, 2'd0, 5'd0);
    mid;
    check("jr_pc_src", 32'(id_pc_src_v[0]), 32'd2);
    tick;
    idle;

    // beq resolves taken: the following ID instruction is squashed.
    tick;
    issue(OP_BEQ, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
    push_wb(1'b0, 1'b0, 2'd0, 5'd2);
    mid;
    check("beq_branch", 32'(id_branch_v[0]), 32'd1);
    tick;
    issue(OP_RTYPE, 6'h20, 5'd1, 5'd2, 5'd14, 1'b1);
    mid;
    check("beq_alu_op", 32'({ex_alu_op_v[0], ex_alu_src2_v[0]}), 32'h2);
    tick;
    idle;
    mid;
    check("flush_bubble", 32'(ex_valid_v[0]), 32'd0);
    repeat (4) tick;

    // mult: three hold cycles, MEM bubbles, then add follows.
    issue(OP_RTYPE, FN_MULT, 5'd1, 5'd2, 5'd0, 1'b0);
    push_wb(1'b0, 1'b1, 2'd0, 5'd0);
    mid;
    check("mult_enter_stall", 32'(stall_v[0]), 32'd0);
    tick;
    issue(OP_RTYPE, 6'h20, 5'd1, 5'd2, 5'd13, 1'b0);
    for (int k = 0; k < 3; k++) begin
      mid;
      check("md_hold", 32'({stall_v[0], muldiv_busy_v[0], mem_valid_v[0], ex_valid_v[0]}),
            32'hd);
      check("md_lat1_free", 32'({stall_v[2], muldiv_busy_v[2]}), 32'd0);
      tick;
    end
    mid;
    check("md_release", 32'({stall_v[0], muldiv_busy_v[0], mem_valid_v[0], ex_valid_v[0]}),
          32'h1);
    tick;
    push_wb(1'b1, 1'b0, 2'd0, 5'd13);
    idle;
    mid;
    check("md_in_mem", 32'({mem_valid_v[0], ex_valid_v[0], ex_dest_v[0]}), 32'h6d);
    repeat (4) tick;

    // flush_id pulsed mid-hold: first load after the hold is a bubble.
    issue(OP_RTYPE, FN_MULTU, 5'd3, 5'd4, 5'd0, 1'b0);
    push_wb(1'b0, 1'b1, 2'd0, 5'd0);
    tick;
    issue(OP_RTYPE, 6'h20, 5'd1, 5'd2, 5'd15, 1'b0);
    tick;
    issue(OP_RTYPE, 6'h20, 5'd1, 5'd2, 5'd15, 1'b1);
    mid;
    check("kill_hold_stall", 32'(stall_v[0]), 32'd1);
    tick;
    issue(OP_RTYPE, 6'h20, 5'd1, 5'd2, 5'd16, 1'b0);
    tick;
    mid;
    check("kill_hold_done", 32'(stall_v[0]), 32'd0);
    tick;
    mid;
    check("kill_bubble", 32'(ex_valid_v[0]), 32'd0);
    tick;
    push_wb(1'b1, 1'b0, 2'd0, 5'd16);
    idle;
    mid;
    check("kill_cleared", 32'({ex_valid_v[0], ex_dest_v[0]}), 32'h30);
    repeat (4) tick;

    // Reset during the second hold cycle aborts the div.
    issue(OP_RTYPE, FN_DIV, 5'd5, 5'd6, 5'd0, 1'b0);
    tick;
    idle;
    mid;
    check("div_busy_1", 32'(muldiv_busy_v[0]), 32'd1);
    tick;
    mid;
    check("div_busy_2", 32'(muldiv_busy_v[0]), 32'd1);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    mid;
    check("abort_clear", 32'({stall_v[0], muldiv_busy_v[0], ex_valid_v[0], mem_valid_v[0],
                              wb_valid_v[0]}), 32'd0);
    tick;
    mid;
    check("abort_idle", 32'({stall_v[0], muldiv_busy_v[0]}), 32'd0);

    repeat (4) tick;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
